// File: rtl/outputbuf.sv
// Line-to-element serializer: accepts a 4-element line per handshake and streams
// the elements out one per transfer, data1 first, with an active + pending line buffer.
module outputbuf #(
  parameter int DATA_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data1,
  input  logic [DATA_W-1:0] data2,
  input  logic [DATA_W-1:0] data3,
  input  logic [DATA_W-1:0] data4,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              out_last,
  output logic              line_done
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t            state_reg, state_next;
  logic [1:0]        idx_reg, idx_next;
  logic              pend_full_reg, pend_full_next;
  logic              line_done_reg, line_done_next;
  logic [DATA_W-1:0] active_reg [4];
  logic [DATA_W-1:0] active_next [4];
  logic [DATA_W-1:0] pend_reg [4];
  logic [DATA_W-1:0] pend_next [4];
  logic [DATA_W-1:0] line_in [4];
  logic [4*DATA_W-1:0] line_flat;

  logic accept, xfer, last_xfer;
  logic load_active_in, load_active_pend, load_pend;

  assign line_flat = {data4, data3, data2, data1};
  assign accept    = in_valid && in_ready;
  assign xfer      = out_valid && out_ready;
  assign last_xfer = xfer && (idx_reg == 2'd3);

  // A new line bypasses pend when nothing is active or the active line is finishing with pend empty.
  assign load_active_in   = accept && ((state_reg == IDLE) || (last_xfer && !pend_full_reg));
  assign load_active_pend = last_xfer && pend_full_reg;
  assign load_pend        = accept && !load_active_in;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = SEND;
      SEND: if (last_xfer && !pend_full_reg && !accept) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state_reg == SEND);
    data_out  = active_reg[idx_reg];
    out_last  = (state_reg == SEND) && (idx_reg == 2'd3);
    in_ready  = !pend_full_reg;
    line_done = line_done_reg;
  end

  always_comb begin
    idx_next = idx_reg;
    if (state_reg == IDLE || last_xfer) begin
      idx_next = 2'd0;
    end else if (xfer) begin
      idx_next = idx_reg + 2'd1;
    end

    pend_full_next = pend_full_reg;
    if (load_active_pend) pend_full_next = 1'b0;
    if (load_pend)        pend_full_next = 1'b1;

    line_done_next = last_xfer;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_reg       <= 2'd0;
      pend_full_reg <= 1'b0;
      line_done_reg <= 1'b0;
    end else begin
      idx_reg       <= idx_next;
      pend_full_reg <= pend_full_next;
      line_done_reg <= line_done_next;
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_elem
      assign line_in[gi] = line_flat[gi*DATA_W +: DATA_W];

      always_comb begin
        active_next[gi] = active_reg[gi];
        if (load_active_in)        active_next[gi] = line_in[gi];
        else if (load_active_pend) active_next[gi] = pend_reg[gi];
        pend_next[gi] = load_pend ? line_in[gi] : pend_reg[gi];
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          active_reg[gi] <= '0;
          pend_reg[gi]   <= '0;
        end else begin
          active_reg[gi] <= active_next[gi];
          pend_reg[gi]   <= pend_next[gi];
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_outputbuf.sv
// Directed bench for outputbuf: a vector table of per-cycle inputs and expected
// outputs, plus hand-written stall and asynchronous-reset sequences.
module tb_outputbuf;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] data1 = '0, data2 = '0, data3 = '0, data4 = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [1:0] data_out;
  logic       out_last;
  logic       line_done;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       iv;
    logic [1:0] d1, d2, d3, d4;
    logic       ordy;
    logic       e_ir;
    logic       e_ov;
    logic [1:0] e_dout;
    logic       e_last;
    logic       e_done;
  } vec_t;

  vec_t tbl[$];

  outputbuf #(.DATA_W(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .data1(data1), .data2(data2), .data3(data3), .data4(data4),
    .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .out_last(out_last), .line_done(line_done)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input int iv, input int a, input int b, input int c, input int d,
                              input int ordy, input int ir, input int ov, input int dout,
                              input int last, input int done);
    vec_t v;
    v.iv = iv[0]; v.d1 = a[1:0]; v.d2 = b[1:0]; v.d3 = c[1:0]; v.d4 = d[1:0];
    v.ordy = ordy[0]; v.e_ir = ir[0]; v.e_ov = ov[0]; v.e_dout = dout[1:0];
    v.e_last = last[0]; v.e_done = done[0];
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs on the falling edge, then compare the registered outputs.
  task automatic step(input string tag, input vec_t v);
    @(negedge clk);
    in_valid = v.iv; data1 = v.d1; data2 = v.d2; data3 = v.d3; data4 = v.d4;
    out_ready = v.ordy;
    #1;
    $display("%s: iv=%0d ordy=%0d ir=%0d ov=%0d dout=%0d last=%0d done=%0d",
             tag, v.iv, v.ordy, in_ready, out_valid, data_out, out_last, line_done);
    check({tag, ".in_ready"},  int'(in_ready),  int'(v.e_ir));
    check({tag, ".out_valid"}, int'(out_valid), int'(v.e_ov));
    check({tag, ".out_last"},  int'(out_last),  int'(v.e_last));
    check({tag, ".line_done"}, int'(line_done), int'(v.e_done));
    if (v.e_ov) check({tag, ".data_out"}, int'(data_out), int'(v.e_dout));
  endtask

  initial begin
    // Columns: iv d1 d2 d3 d4 ordy | ir ov dout last done
    // Single line {1,2,0,3}
    tbl.push_back(mk(1, 1,2,0,3, 1,  1,0,0,0,0));
    tbl.push_back(mk(0, 0,0,0,0, 1,  1,1,1,0,0));
    tbl.push_back(mk(0, 0,0,0,0, 1,  1,1,2,0,0));
    tbl.push_back(mk(0, 0,0,0,0, 1,  1,1,0,0,0));
    tbl.push_back(mk(0, 0,0,0,0, 1,  1,1,3,1,0));
    tbl.push_back(mk(0, 0,0,0,0, 1,  1,0,0,0,1));
    tbl.push_back(mk(0, 0,0,0,0, 1,  1,0,0,0,0));
    // Back-to-back {1,2,0,3} then {3,0,1,2}
    tbl.push_back(mk(1, 1,2,0,3, 1,  1,0,0,0,0));
    tbl.push_back(mk(1, 3,0,1,2, 1,  1,1,1,0,0));
    tbl.push_back(mk(0, 0,0,0,0, 1,  0,1,2,0,0));
    tbl.push_back(mk(0, 0,0,0,0, 1,  0,1,0,0,0));
    tbl.push_back(mk(0, 0,0,0,0, 1,  0,1,3,1,0));
    tbl.push_back(mk(0, 0,0,0,0, 1,  1,1,3,0,1));
    tbl.push_back(mk(0, 0,0,0,0, 1,  1,1,0,0,0));
    tbl.push_back(mk(0, 0,0,0,0, 1,  1,1,1,0,0));
    tbl.push_back(mk(0, 0,0,0,0, 1,  1,1,2,1,0));
    tbl.push_back(mk(0, 0,0,0,0, 1,  1,0,0,0,1));
    // Accept on element-3 transfer with pend empty goes straight to active
    tbl.push_back(mk(1, 2,1,3,0, 1,  1,0,0,0,0));
    tbl.push_back(mk(0, 0,0,0,0, 1,  1,1,2,0,0));
    tbl.push_back(mk(0, 0,0,0,0, 1,  1,1,1,0,0));
    tbl.push_back(mk(0, 0,0,0,0, 1,  1,1,3,0,0));
    tbl.push_back(mk(1, 1,1,2,2, 1,  1,1,0,1,0));
    tbl.push_back(mk(0, 0,0,0,0, 1,  1,1,1,0,1));
    tbl.push_back(mk(0, 0,0,0,0, 1,  1,1,1,0,0));
    tbl.push_back(mk(0, 0,0,0,0, 1,  1,1,2,0,0));
    tbl.push_back(mk(0, 0,0,0,0, 1,  1,1,2,1,0));
    tbl.push_back(mk(0, 0,0,0,0, 1,  1,0,0,0,1));
    // Three lines: C blocked while pend full, emitted intact after B
    tbl.push_back(mk(1, 0,1,2,3, 1,  1,0,0,0,0));
    tbl.push_back(mk(1, 3,2,1,0, 1,  1,1,0,0,0));
    tbl.push_back(mk(1, 1,3,1,3, 1,  0,1,1,0,0));
    tbl.push_back(mk(1, 1,3,1,3, 1,  0,1,2,0,0));
    tbl.push_back(mk(1, 1,3,1,3, 1,  0,1,3,1,0));
    tbl.push_back(mk(1, 1,3,1,3, 1,  1,1,3,0,1));
    tbl.push_back(mk(0, 0,0,0,0, 1,  0,1,2,0,0));
    tbl.push_back(mk(0, 0,0,0,0, 1,  0,1,1,0,0));
    tbl.push_back(mk(0, 0,0,0,0, 1,  0,1,0,1,0));
    tbl.push_back(mk(0, 0,0,0,0, 1,  1,1,1,0,1));
    tbl.push_back(mk(0, 0,0,0,0, 1,  1,1,3,0,0));
    tbl.push_back(mk(0, 0,0,0,0, 1,  1,1,1,0,0));
    tbl.push_back(mk(0, 0,0,0,0, 1,  1,1,3,1,0));
    tbl.push_back(mk(0, 0,0,0,0, 1,  1,0,0,0,1));

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset.out_valid", int'(out_valid), 0);
    check("reset.in_ready",  int'(in_ready),  1);
    check("reset.data_out",  int'(data_out),  0);
    check("reset.out_last",  int'(out_last),  0);
    check("reset.line_done", int'(line_done), 0);
    rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      step($sformatf("vec[%0d]", i), tbl[i]);
    end

    // Stall while element 1 (=2) is shown
    step("stall[0]", mk(1, 1,2,0,3, 1,  1,0,0,0,0));
    step("stall[1]", mk(0, 0,0,0,0, 1,  1,1,1,0,0));
    step("stall[2]", mk(0, 0,0,0,0, 0,  1,1,2,0,0));
    step("stall[3]", mk(0, 0,0,0,0, 0,  1,1,2,0,0));
    step("stall[4]", mk(0, 0,0,0,0, 0,  1,1,2,0,0));
    step("stall[5]", mk(0, 0,0,0,0, 1,  1,1,2,0,0));
    step("stall[6]", mk(0, 0,0,0,0, 1,  1,1,0,0,0));
    step("stall[7]", mk(0, 0,0,0,0, 1,  1,1,3,1,0));
    step("stall[8]", mk(0, 0,0,0,0, 1,  1,0,0,0,1));

    // Async reset with idx==2 and pend full
    step("arst[0]", mk(1, 0,1,2,3, 1,  1,0,0,0,0));
    step("arst[1]", mk(1, 3,3,3,3, 1,  1,1,0,0,0));
    step("arst[2]", mk(0, 0,0,0,0, 1,  0,1,1,0,0));
    step("arst[3]", mk(0, 0,0,0,0, 1,  0,1,2,0,0));
    #1 rst = 1'b0;
    #1;
    $display("arst.mid: ov=%0d ir=%0d dout=%0d", out_valid, in_ready, data_out);
    check("arst.mid.out_valid", int'(out_valid), 0);
    check("arst.mid.in_ready",  int'(in_ready),  1);
    check("arst.mid.out_last",  int'(out_last),  0);
    check("arst.mid.data_out",  int'(data_out),  0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    step("arst[4]", mk(0, 0,0,0,0, 1,  1,0,0,0,0));
    step("arst[5]", mk(1, 2,3,1,0, 1,  1,0,0,0,0));
    step("arst[6]", mk(0, 0,0,0,0, 1,  1,1,2,0,0));
    step("arst[7]", mk(0, 0,0,0,0, 1,  1,1,3,0,0));
    step("arst[8]", mk(0, 0,0,0,0, 1,  1,1,1,0,0));
    step("arst[9]", mk(0, 0,0,0,0, 1,  1,1,0,1,0));
    step("arst[10]", mk(0, 0,0,0,0, 1, 1,0,0,0,1));
    step("arst[11]", mk(0, 0,0,0,0, 1, 1,0,0,0,0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
